fifo_sync_param: RTL

Single-clock, parametrised synchronous FIFO for the LAB4 datapath. It keeps the push/pop/full/empty handshake of the existing FIFO and adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. It is used wherever producer and consumer share one clock, so no clock-domain crossing is needed.

---
 rtl/fifo_sync_param.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO: registered read data, occupancy count,
// programmable almost-full/almost-empty, sticky overflow/underflow and a
// synchronous flush that outranks push and pop.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pop,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  push_rej;
    logic                  pop_rej;

    // Status decoded from the count register alone, so flags never see
    // same-cycle inputs.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    // Acceptance uses pre-edge flags; a full FIFO still pops, an empty one
    // still pushes, and clear suppresses everything including error flags.
    assign push_ok  = push & ~full  & ~clear;
    assign pop_ok   = pop  & ~empty & ~clear;
    assign push_rej = push &  full  & ~clear;
    assign pop_rej  = pop  &  empty & ~clear;

    // All FIFO state; memory is deliberately left out of reset and flush.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= data_in;
                wr_ptr              <= wr_ptr + CW'(1);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + CW'(1);
            end
            if (push_rej) overflow  <= 1'b1;
            if (pop_rej)  underflow <= 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
